seq_mul_sched: RTL and testbench

Round-robin scheduler that shares one seq_mul instance between NREQ requesters. It latches the winning requester's operands and pulses the multiplier's start for one cycle. It then waits the fixed multiplier latency, captures the product and returns it with the requester's index. It sits between the requesting units and the seq_mul instance; seq_mul is instantiated outside this block.

---
 rtl/seq_mul_pkg.sv | 19 +
 rtl/seq_mul_sched_rr_arbiter.sv | 35 +++
 rtl/seq_mul_sched.sv | 142 ++++++++++++++
 tb/tb_seq_mul_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared definitions for the seq_mul scheduler: FSM encoding and index-width helper.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Minimum width of 1 keeps single-value fields legal.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_mul_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the requester after ptr_i has highest priority.
module rr_arbiter
  import seq_mul_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            valid_o
);

  logic           found;
  logic [IDW-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = IDW'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/seq_mul_sched.sv
// Shares one external seq_mul between NREQ requesters: arbitrate, issue, wait the
// fixed multiplier latency, then return the product tagged with the requester index.
//
//   state | meaning
//   IDLE  | no operation in flight, arbitrating
//   ISSUE | start pulse to seq_mul with latched operands, ack to winner
//   WAIT  | counting down the multiplier latency
//   DONE  | result_valid pulse, arbitrating for the next operation
module seq_mul_sched
  import seq_mul_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 4,
  parameter int MUL_LAT = 5,
  localparam int IDW    = clog2(NREQ),
  localparam int CNTW   = clog2(MUL_LAT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic                  mul_start,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [2*WIDTH-1:0]    mul_op,
  output logic [2*WIDTH-1:0]    result,
  output logic [IDW-1:0]        result_id,
  output logic                  result_valid
);

  state_e              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [IDW-1:0]      gid_q, gid_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  result_q, result_d;
  logic [IDW-1:0]      result_id_q, result_id_d;

  logic [NREQ-1:0]     arb_gnt;
  logic [IDW-1:0]      arb_idx;
  logic                arb_valid;
  logic                grant_go;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign grant_go = arb_valid && (state_q == IDLE || state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(NREQ - 1);
      gnt_q       <= '0;
      gid_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_id_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gid_q       <= gid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      result_id_q <= result_id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: state_d = arb_valid ? ISSUE : IDLE;
      ISSUE:      state_d = WAIT;
      WAIT:       if (cnt_q == '0) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gid_d       = gid_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    result_id_d = result_id_q;
    if (grant_go) begin
      ptr_d = arb_idx;
      gnt_d = arb_gnt;
      gid_d = arb_idx;
      for (int i = 0; i < NREQ; i++) begin
        if (arb_gnt[i]) begin
          a_d = req_a[i*WIDTH +: WIDTH];
          b_d = req_b[i*WIDTH +: WIDTH];
        end
      end
    end
    if (state_q == ISSUE) cnt_d = CNTW'(MUL_LAT - 1);
    if (state_q == WAIT) begin
      if (cnt_q == '0) begin
        result_d    = mul_op;
        result_id_d = gid_q;
      end else begin
        cnt_d = cnt_q - CNTW'(1);
      end
    end
  end

  always_comb begin
    ack          = '0;
    mul_start    = 1'b0;
    mul_a        = '0;
    mul_b        = '0;
    result_valid = (state_q == DONE);
    busy         = (state_q != IDLE);
    if (state_q == ISSUE) begin
      ack       = gnt_q;
      mul_start = 1'b1;
      mul_a     = a_q;
      mul_b     = b_q;
    end
  end

  assign result    = result_q;
  assign result_id = result_id_q;

endmodule

// File: tb/tb_seq_mul_sched.sv
// Scoreboard bench for seq_mul_sched with a behavioural seq_mul model on the mul_* ports.
module tb_seq_mul_sched;
  localparam int NREQ = 4, WIDTH = 4, MUL_LAT = 5;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ-1:0]       ack;
  logic                  busy, mul_start, result_valid;
  logic [WIDTH-1:0]      mul_a, mul_b;
  logic [2*WIDTH-1:0]    mul_op, result;
  logic [1:0]            result_id;

  seq_mul_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .ack(ack), .busy(busy), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_op(mul_op), .result(result), .result_id(result_id), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // seq_mul model: product becomes visible MUL_LAT edges after start is sampled
  logic [7:0] ma = 8'd0, mb = 8'd0;
  int         mcnt = 0;
  logic       mhave = 1'b0;
  always @(posedge clk) begin
    if (mul_start) begin
      ma    <= {4'd0, mul_a};
      mb    <= {4'd0, mul_b};
      mcnt  <= MUL_LAT - 1;
      mhave <= 1'b1;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
    end
  end
  assign mul_op = (mhave && mcnt == 0) ? ma * mb : 8'hA5;

  typedef struct {int prod; int id; int cyc;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   ack_log[$];
  int   checks = 0, errors = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void chk_zero(string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mul_start"}, mul_start, 0);
    chk({tag, "_mul_a"}, mul_a, 0);
    chk({tag, "_mul_b"}, mul_b, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_result_id"}, result_id, 0);
    chk({tag, "_result_valid"}, result_valid, 0);
  endfunction

  // Monitor: idle operand gating, ack one-hotness, scoreboard compare on result_valid
  always @(negedge clk) begin
    if (!mul_start) begin
      chk("mul_a_idle", mul_a, 0);
      chk("mul_b_idle", mul_b, 0);
    end
    if (ack != '0) begin
      chk("ack_onehot", $onehot(ack), 1);
      for (int i = 0; i < NREQ; i++) if (ack[i]) ack_log.push_back(i);
    end
    if (result_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got result %0d id %0d, none expected (t=%0t)",
                 result, result_id, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("result", result, mon_e.prod);
        chk("result_id", result_id, mon_e.id);
        chk("result_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic set_req(int i, int a, int b);
    req[i] = 1'b1;
    req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
    req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  task automatic expect_res(int p, int id, int c);
    exp_t x;
    x.prod = p;
    x.id   = id;
    x.cyc  = c;
    sb.push_back(x);
  endtask

  task automatic wait_ack_drop(int i);
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (ack[i]) begin
        seen   = 1'b1;
        req[i] = 1'b0;
      end
    end
    chk("ack_seen", seen, 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(posedge clk);
      #1;
      if (!busy && sb.size() == 0) ok = 1'b1;
    end
    chk("return_idle", ok, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_zero("rst_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int E;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req = '0;
    req_a = '0;
    req_b = '0;
    #2;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single operation, latency and one-cycle start pulse
    @(posedge clk);
    #1;
    set_req(0, 5, 9);
    E = cyc + 1;
    expect_res(45, 0, E + 1 + MUL_LAT);
    @(posedge clk);
    #1;
    chk("t1_ack", ack, 4'b0001);
    chk("t1_mul_start", mul_start, 1);
    chk("t1_mul_a", mul_a, 5);
    chk("t1_mul_b", mul_b, 9);
    req[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("t1_start_pulse", mul_start, 0);
    chk("t1_busy", busy, 1);
    wait_idle();

    // Two simultaneous requesters; second issues straight from DONE
    do_reset();
    @(posedge clk);
    #1;
    set_req(0, 13, 5);
    set_req(2, 15, 15);
    E = cyc + 1;
    expect_res(65, 0, E + 1 + MUL_LAT);
    expect_res(225, 2, E + 1 + MUL_LAT + MUL_LAT + 2);
    wait_ack_drop(0);
    wait_ack_drop(2);
    wait_idle();

    // All requesters held: rotation 0,1,2,3,0
    do_reset();
    ack_log.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) set_req(i, i + 2, i + 7);
    E = cyc + 1;
    expect_res(14, 0, E + 6);
    expect_res(24, 1, E + 13);
    expect_res(36, 2, E + 20);
    expect_res(50, 3, E + 27);
    expect_res(14, 0, E + 34);
    for (int n = 0; n < 60 && ack_log.size() < 5; n++) begin
      @(posedge clk);
      #1;
    end
    req = '0;
    chk("t3_grant_count", ack_log.size(), 5);
    for (int k = 0; k < 5; k++)
      if (ack_log.size() > k) chk("t3_grant_order", ack_log[k], exp_order[k]);
    wait_idle();

    // Reset mid-WAIT aborts the operation; next request runs normally
    do_reset();
    @(posedge clk);
    #1;
    set_req(0, 7, 7);
    wait_ack_drop(0);
    repeat (2) @(posedge clk);
    chk("t4_busy_in_wait", busy, 1);
    do_reset();
    @(posedge clk);
    #1;
    set_req(1, 3, 4);
    E = cyc + 1;
    expect_res(12, 1, E + 1 + MUL_LAT);
    wait_ack_drop(1);
    wait_idle();
    chk("t4_result_hold", result, 12);

    // Operands changed right after ack do not disturb the operation in flight
    @(posedge clk);
    #1;
    set_req(2, 11, 13);
    E = cyc + 1;
    expect_res(143, 2, E + 1 + MUL_LAT);
    wait_ack_drop(2);
    req_a[2*WIDTH +: WIDTH] = 4'hF;
    req_b[2*WIDTH +: WIDTH] = 4'hF;
    wait_idle();

    // Idle: nothing issues and the last result holds
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_mul_start", mul_start, 0);
      chk("idle_result", result, 143);
      chk("idle_result_id", result_id, 2);
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
